// File: rtl/oisc8_fetch.sv
// oisc8_fetch: instruction fetch / sequencing stage of the oisc8 core.
// Owns the program counter, the BRPT0/BRPT1 branch pointer and BRZ
// resolution, and drives the IBus instruction word plus its bus reset.
// Optional feature macro: OISC8_HALT_EN (executing 13'h1FFF halts the core).
module oisc8_fetch #(
  parameter int PC_WIDTH   = 16,
  parameter int RST_CYCLES = 2,
  parameter int RESET_PC   = 0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] rom_addr,
  output logic                rom_rd,
  input  logic [12:0]         rom_data,
  input  logic                stall,
  input  logic [7:0]          bus_data,
  output logic [12:0]         instr,
  output logic                instr_valid,
  output logic                bus_rst,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         brpt,
  output logic                halted
);

  localparam logic [12:0]         NOP       = 13'h0F00;
  localparam logic [3:0]          DST_BRPT0 = 4'h2;
  localparam logic [3:0]          DST_BRPT1 = 4'h3;
  localparam logic [3:0]          DST_BRZ   = 4'h4;
  localparam int                  CNT_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] START_PC  = PC_WIDTH'(RESET_PC);

  typedef enum logic [1:0] {
    ST_RST_HOLD,
    ST_PRIME,
    ST_RUN,
    ST_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    rstCnt_q, rstCnt_d;
  logic [PC_WIDTH-1:0] fetchPtr_q, fetchPtr_d;
  logic                pending_q, pending_d;
  logic [PC_WIDTH-1:0] pendPc_q, pendPc_d;
  logic [12:0]         curInstr_q, curInstr_d;
  logic [PC_WIDTH-1:0] curPc_q, curPc_d;
  logic                curValid_q, curValid_d;
  logic [15:0]         brpt_q, brpt_d;

  logic                exec;
  logic [7:0]          opValue;
  logic                brzTaken;
  logic [PC_WIDTH-1:0] brTarget;
  logic [PC_WIDTH-1:0] fetchAddr;
  logic                haltReq;

  // The current word executes only when it is real and the core is not held;
  // BRZ always sees the branch pointer as it was before this cycle's update.
  assign exec     = (state_q == ST_RUN) && curValid_q && !stall;
  assign opValue  = curInstr_q[12] ? curInstr_q[7:0] : bus_data;
  assign brzTaken = exec && (curInstr_q[11:8] == DST_BRZ) && (opValue == 8'h00);
  assign brTarget = PC_WIDTH'(brpt_q);
  assign pc       = curPc_q;
  assign brpt     = brpt_q;

`ifdef OISC8_HALT_EN
  assign haltReq = exec && (curInstr_q == 13'h1FFF);
  assign halted  = (state_q == ST_HALT);
`else
  assign haltReq = 1'b0;
  assign halted  = 1'b0;
`endif

  // State and datapath registers; reset discards any in-flight fetch, branch or stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RST_HOLD;
      rstCnt_q   <= '0;
      fetchPtr_q <= START_PC;
      pending_q  <= 1'b0;
      pendPc_q   <= START_PC;
      curInstr_q <= NOP;
      curPc_q    <= START_PC;
      curValid_q <= 1'b0;
      brpt_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      rstCnt_q   <= rstCnt_d;
      fetchPtr_q <= fetchPtr_d;
      pending_q  <= pending_d;
      pendPc_q   <= pendPc_d;
      curInstr_q <= curInstr_d;
      curPc_q    <= curPc_d;
      curValid_q <= curValid_d;
      brpt_q     <= brpt_d;
    end
  end

  // Next-state and output logic: bus reset hold, ROM prime, steady fetch, halt.
  always_comb begin
    state_d     = state_q;
    rstCnt_d    = rstCnt_q;
    fetchPtr_d  = fetchPtr_q;
    pending_d   = pending_q;
    pendPc_d    = pendPc_q;
    curInstr_d  = curInstr_q;
    curPc_d     = curPc_q;
    curValid_d  = curValid_q;
    brpt_d      = brpt_q;
    fetchAddr   = fetchPtr_q;
    rom_rd      = 1'b0;
    rom_addr    = fetchPtr_q;
    bus_rst     = 1'b0;
    instr       = NOP;
    instr_valid = 1'b0;

    case (state_q)
      ST_RST_HOLD: begin
        bus_rst = 1'b1;
        if (rstCnt_q == CNT_LAST) begin
          state_d = ST_PRIME;
        end else begin
          rstCnt_d = rstCnt_q + 1'b1;
        end
      end

      ST_PRIME: begin
        rom_rd     = 1'b1;
        fetchPtr_d = fetchPtr_q + 1'b1;
        pending_d  = 1'b1;
        pendPc_d   = fetchPtr_q;
        state_d    = ST_RUN;
      end

      ST_RUN: begin
        if (!stall) begin
          instr       = curValid_q ? curInstr_q : NOP;
          instr_valid = curValid_q;
          if (exec && (curInstr_q[11:8] == DST_BRPT0)) begin
            brpt_d[7:0] = opValue;
          end
          if (exec && (curInstr_q[11:8] == DST_BRPT1)) begin
            brpt_d[15:8] = opValue;
          end
          if (haltReq) begin
            state_d    = ST_HALT;
            pending_d  = 1'b0;
            curValid_d = 1'b0;
          end else begin
            fetchAddr  = brzTaken ? brTarget : fetchPtr_q;
            rom_rd     = 1'b1;
            rom_addr   = fetchAddr;
            fetchPtr_d = fetchAddr + 1'b1;
            pending_d  = 1'b1;
            pendPc_d   = fetchAddr;
            curValid_d = pending_q && !brzTaken;
            if (pending_q) begin
              curInstr_d = rom_data;
              curPc_d    = pendPc_q;
            end
          end
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_RST_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_oisc8_fetch.sv
// tb_oisc8_fetch: directed self-checking bench for oisc8_fetch.
// Main instance uses PC_WIDTH=16; a second instance (PC_WIDTH=4, RESET_PC=14)
// covers pointer wrap and, when OISC8_HALT_EN is defined, the halt word.
module tb_oisc8_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [7:0]  busData;
  logic        stall4;

  logic [15:0] romAddr;
  logic        romRd;
  logic [12:0] romData;
  logic [12:0] instr;
  logic        instrValid;
  logic        busRst;
  logic [15:0] pc;
  logic [15:0] brpt;
  logic        halted;

  logic [3:0]  romAddr4;
  logic        romRd4;
  logic [12:0] romData4;
  logic [12:0] instr4;
  logic        instrValid4;
  logic        busRst4;
  logic [3:0]  pc4;
  logic [15:0] brpt4;
  logic        halted4;

  logic [12:0] rom  [256];
  logic [12:0] rom4 [16];

  int checks   = 0;
  int failures = 0;

  oisc8_fetch #(.PC_WIDTH(16), .RST_CYCLES(2), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .rom_addr(romAddr), .rom_rd(romRd), .rom_data(romData),
    .stall(stall), .bus_data(busData), .instr(instr), .instr_valid(instrValid),
    .bus_rst(busRst), .pc(pc), .brpt(brpt), .halted(halted)
  );

  oisc8_fetch #(.PC_WIDTH(4), .RST_CYCLES(2), .RESET_PC(14)) dut4 (
    .clk(clk), .rst(rst), .rom_addr(romAddr4), .rom_rd(romRd4), .rom_data(romData4),
    .stall(stall4), .bus_data(busData), .instr(instr4), .instr_valid(instrValid4),
    .bus_rst(busRst4), .pc(pc4), .brpt(brpt4), .halted(halted4)
  );

  always #5 clk = ~clk;

  // Synchronous ROM models: data appears the cycle after a read and holds otherwise.
  always @(posedge clk) if (romRd) romData <= rom[romAddr[7:0]];
  always @(posedge clk) if (romRd4) romData4 <= rom4[romAddr4];

  task automatic loadFiller;
    for (int i = 0; i < 256; i++) rom[i] = 13'h0E00 | 13'(i);
  endtask

  // Reset both instances; returns so the next negedge shows the first word.
  task automatic doReset;
    rst = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    loadFiller();
    rom[0] = 13'h1203; rom[1] = 13'h1305; rom[2] = 13'h0000; rom[3] = 13'h0F00;
    rst = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busRst !== 1'b1) begin failures++; $display("[TB] FAIL reset_bus_rst got=%b exp=1", busRst); end
    checks++; if (romRd !== 1'b0) begin failures++; $display("[TB] FAIL reset_rom_rd got=%b exp=0", romRd); end
    checks++; if (instr !== 13'h0F00) begin failures++; $display("[TB] FAIL reset_instr got=%h exp=0f00", instr); end
    checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", instrValid); end
    checks++; if (brpt !== 16'h0000 || pc !== 16'h0000 || halted !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_regs got brpt=%h pc=%h halted=%b exp 0/0/0", brpt, pc, halted);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (busRst !== 1'b1 || romRd !== 1'b0) begin
      failures++; $display("[TB] FAIL hold_edge1 got bus_rst=%b rom_rd=%b exp 1/0", busRst, romRd);
    end
    @(negedge clk); #1;
    checks++; if (busRst !== 1'b0 || romRd !== 1'b1 || romAddr !== 16'h0000) begin
      failures++; $display("[TB] FAIL prime got bus_rst=%b rom_rd=%b addr=%h exp 0/1/0000", busRst, romRd, romAddr);
    end
    checks++; if (instrValid !== 1'b0) begin failures++; $display("[TB] FAIL prime_valid got=%b exp=0", instrValid); end
    @(negedge clk); #1;
    checks++; if (instrValid !== 1'b0 || romAddr !== 16'h0001) begin
      failures++; $display("[TB] FAIL run_first got valid=%b addr=%h exp 0/0001", instrValid, romAddr);
    end
  endtask

  task automatic test_straight;
    logic [12:0] expWord [4];
    expWord[0] = 13'h1203; expWord[1] = 13'h1305; expWord[2] = 13'h0000; expWord[3] = 13'h0F00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (instr !== expWord[i] || instrValid !== 1'b1 || pc !== 16'(i)) begin
        failures++; $display("[TB] FAIL straight_%0d got instr=%h valid=%b pc=%h exp %h/1/%h", i, instr, instrValid, pc, expWord[i], 16'(i));
      end
    end
    checks++; if (brpt !== 16'h0503) begin failures++; $display("[TB] FAIL straight_brpt got=%h exp=0503", brpt); end
  endtask

  task automatic test_branch;
    loadFiller();
    rom[0] = 13'h1210; rom[1] = 13'h1301; rom[2] = 13'h1400;
    doReset();
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++; if (instr !== 13'h1400 || instrValid !== 1'b1) begin
      failures++; $display("[TB] FAIL brz_present got instr=%h valid=%b exp 1400/1", instr, instrValid);
    end
    checks++; if (romAddr !== 16'h0110 || romRd !== 1'b1) begin
      failures++; $display("[TB] FAIL brz_redirect got addr=%h rd=%b exp 0110/1", romAddr, romRd);
    end
    checks++; if (brpt !== 16'h0110) begin failures++; $display("[TB] FAIL brz_brpt got=%h exp=0110", brpt); end
    @(negedge clk); #1;
    checks++; if (instr !== 13'h0F00 || instrValid !== 1'b0) begin
      failures++; $display("[TB] FAIL brz_bubble got instr=%h valid=%b exp 0f00/0", instr, instrValid);
    end
    @(negedge clk); #1;
    checks++; if (instr !== 13'h0E10 || instrValid !== 1'b1 || pc !== 16'h0110) begin
      failures++; $display("[TB] FAIL brz_target got instr=%h valid=%b pc=%h exp 0e10/1/0110", instr, instrValid, pc);
    end
    @(negedge clk); #1;
    checks++; if (instr !== 13'h0E11 || pc !== 16'h0111) begin
      failures++; $display("[TB] FAIL brz_after got instr=%h pc=%h exp 0e11/0111", instr, pc);
    end
  endtask

  task automatic test_not_taken;
    loadFiller();
    rom[0] = 13'h1210; rom[1] = 13'h1300; rom[2] = 13'h0400;
    busData = 8'h05;
    doReset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (instr !== 13'h0400 || romAddr !== 16'h0004) begin
      failures++; $display("[TB] FAIL nt_present got instr=%h addr=%h exp 0400/0004", instr, romAddr);
    end
    @(negedge clk); #1;
    checks++; if (instr !== 13'h0E03 || instrValid !== 1'b1 || pc !== 16'h0003) begin
      failures++; $display("[TB] FAIL nt_next got instr=%h valid=%b pc=%h exp 0e03/1/0003", instr, instrValid, pc);
    end
    checks++; if (brpt !== 16'h0010) begin failures++; $display("[TB] FAIL nt_brpt got=%h exp=0010", brpt); end
  endtask

  task automatic test_stall;
    loadFiller();
    busData = 8'h00;
    doReset();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1'b1;
      #1;
      checks++; if (instr !== 13'h0F00 || instrValid !== 1'b0 || romRd !== 1'b0 || pc !== 16'h0005) begin
        failures++; $display("[TB] FAIL stall_%0d got instr=%h valid=%b rd=%b pc=%h exp 0f00/0/0/0005", i, instr, instrValid, romRd, pc);
      end
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    checks++; if (instr !== 13'h0E05 || instrValid !== 1'b1 || pc !== 16'h0005) begin
      failures++; $display("[TB] FAIL stall_release got instr=%h valid=%b pc=%h exp 0e05/1/0005", instr, instrValid, pc);
    end
    @(negedge clk); #1;
    checks++; if (instr !== 13'h0E06 || pc !== 16'h0006) begin
      failures++; $display("[TB] FAIL stall_next got instr=%h pc=%h exp 0e06/0006", instr, pc);
    end
  endtask

  task automatic test_wrap_halt;
    doReset();
    @(negedge clk); #1;
    checks++; if (instr4 !== 13'h0E0E || pc4 !== 4'hE || instrValid4 !== 1'b1) begin
      failures++; $display("[TB] FAIL wrap_e got instr=%h pc=%h valid=%b exp 0e0e/e/1", instr4, pc4, instrValid4);
    end
    @(negedge clk); #1;
    checks++; if (pc4 !== 4'hF) begin failures++; $display("[TB] FAIL wrap_f got pc=%h exp=f", pc4); end
    @(negedge clk); #1;
    checks++; if (pc4 !== 4'h0 || instr4 !== 13'h0E00) begin
      failures++; $display("[TB] FAIL wrap_0 got pc=%h instr=%h exp 0/0e00", pc4, instr4);
    end
    @(negedge clk); #1;
    checks++; if (instr4 !== 13'h1FFF || instrValid4 !== 1'b1 || pc4 !== 4'h1) begin
      failures++; $display("[TB] FAIL halt_word got instr=%h valid=%b pc=%h exp 1fff/1/1", instr4, instrValid4, pc4);
    end
    @(negedge clk); #1;
`ifdef OISC8_HALT_EN
    checks++; if (halted4 !== 1'b1 || romRd4 !== 1'b0 || instrValid4 !== 1'b0 || instr4 !== 13'h0F00) begin
      failures++; $display("[TB] FAIL halt_enter got halted=%b rd=%b valid=%b instr=%h exp 1/0/0/0f00", halted4, romRd4, instrValid4, instr4);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (halted4 !== 1'b1 || romRd4 !== 1'b0) begin
      failures++; $display("[TB] FAIL halt_hold got halted=%b rd=%b exp 1/0", halted4, romRd4);
    end
`else
    checks++; if (halted4 !== 1'b0 || instrValid4 !== 1'b1 || pc4 !== 4'h2 || instr4 !== 13'h0E02) begin
      failures++; $display("[TB] FAIL halt_noop got halted=%b valid=%b pc=%h instr=%h exp 0/1/2/0e02", halted4, instrValid4, pc4, instr4);
    end
`endif
    rst = 1'b0;
    #1;
    checks++; if (halted4 !== 1'b0 || busRst4 !== 1'b1 || brpt4 !== 16'h0000) begin
      failures++; $display("[TB] FAIL halt_reset got halted=%b bus_rst=%b brpt=%h exp 0/1/0000", halted4, busRst4, brpt4);
    end
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    stall4 = 1'b0;
    busData = 8'h00;
    romData = 13'h0000;
    romData4 = 13'h0000;
    for (int i = 0; i < 16; i++) rom4[i] = 13'h0E00 | 13'(i);
    rom4[1] = 13'h1FFF;
    test_reset();
    test_straight();
    test_branch();
    test_not_taken();
    test_stall();
    test_wrap_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
